multi_counter: RTL and testbench
================================

MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the per-channel count width in bits.
REQ-002 The block SHALL have parameter NCH, default 4, giving the number of independent channels (1..16).
REQ-003 The block SHALL have parameter PW, default 16, giving the prescaler divisor width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, NCH bits: per-channel count enable.
REQ-007 The block SHALL have port clear, input, NCH bits: per-channel synchronous clear to 0.
REQ-008 The block SHALL have port load, input, NCH bits: per-channel load strobe.
REQ-009 The block SHALL have port load_value, input, NCH*WIDTH bits: load data; channel i is at [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port down, input, NCH bits: per-channel direction; 0 counts up, 1 counts down.
REQ-011 The block SHALL have port saturate, input, NCH bits: per-channel mode; 0 wraps, 1 saturates.
REQ-012 The block SHALL have port prescale_div, input, PW bits: shared prescaler divisor.
REQ-013 The block SHALL have port compare_value, input, NCH*WIDTH bits: per-channel compare value.
REQ-014 The block SHALL have port snap, input, 1 bit: snapshot request.
REQ-015 The block SHALL have port count, output, NCH*WIDTH bits: live registered counts.
REQ-016 The block SHALL have port snap_count, output, NCH*WIDTH bits: counts captured by the last snapshot.
REQ-017 The block SHALL have port snap_valid, output, 1 bit: one-cycle pulse marking a new snapshot.
REQ-018 The block SHALL have port match, output, NCH bits: one-cycle pulse when a channel counts onto its compare value.
REQ-019 The block SHALL have port tc, output, NCH bits: one-cycle pulse on a wrap or on reaching a saturation limit.

Function
REQ-020 A shared prescaler SHALL run from 0 up to prescale_div and assert an internal tick in the cycle it equals prescale_div, then return to 0; prescale_div=0 SHALL give a tick every cycle.
REQ-021 A change of prescale_div SHALL take effect at once; if the prescaler already exceeds the new divisor, it SHALL tick and restart at 0.
REQ-022 Per-channel update priority SHALL be: clear, then load, then a count step (enable[i] and tick), then hold.
REQ-023 A count step SHALL add +1 or -1 according to down[i], with the result visible on count one cycle after the qualifying edge.
REQ-024 In wrap mode, stepping up from all-ones SHALL give 0 and stepping down from 0 SHALL give all-ones; either case SHALL pulse tc[i].
REQ-025 In saturate mode, a step at all-ones (up) or at 0 (down) SHALL hold the count and pulse tc[i] on every such blocked step.
REQ-026 match[i] SHALL pulse for one cycle, registered, in the cycle after a count step makes count[i] equal compare_value[i]; a clear or load to that value SHALL NOT pulse match[i].
REQ-027 On snap, all NCH counts as they stand before that edge's update SHALL be captured atomically into snap_count, and snap_valid SHALL pulse one cycle later.
REQ-028 With snap held high, the block SHALL capture and pulse snap_valid every cycle.
REQ-029 A clear or load in the same cycle as snap SHALL NOT corrupt the capture; the pre-update value SHALL be captured.
REQ-030 Channels SHALL be fully independent; only the tick and snap are shared.

Reset
REQ-031 While reset is high, count, snap_count and the prescaler SHALL be 0, and snap_valid, match and tc SHALL be 0.
REQ-032 Reset SHALL override every other input, including mid-operation.
REQ-033 The first possible tick SHALL come prescale_div+1 cycles after reset deasserts.

Structure
REQ-034 A package multi_counter_pkg SHALL hold the direction constants (UP=0, DOWN=1), the mode constants (WRAP=0, SAT=1) and the default parameter values.
REQ-035 A sub-module counter_channel SHALL implement one channel (clear/load/step/wrap/saturate/match/tc), instantiated NCH times by generate; the prescaler and snapshot logic SHALL sit in the top level.

Verification
REQ-036 Ch0 up with prescale_div=0, enable for 5 cycles -> count0=5, no tc.
REQ-037 Ch1 in wrap mode loaded with 2^WIDTH-1, one up step -> count1=0 and a single tc[1] pulse; the same test in saturate mode -> count1 stays 2^WIDTH-1 and tc[1] pulses on each step.
REQ-038 prescale_div=3, ch2 enabled for 20 cycles after reset -> count2=5, with steps exactly 4 cycles apart.
REQ-039 compare_value3=10, ch3 counts up from 0 -> a single match[3] pulse the cycle after count3=10; a load of 10 -> no match.
REQ-040 Counts 7/8/9/10, snap together with clear0 -> snap_count={10,9,8,7}, snap_valid one cycle later, count0=0.
REQ-041 Reset asserted mid-count with snap and load high -> all outputs 0 on the next cycle, and counting resumes per REQ-033.

Source files
------------

// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: shared direction/mode constants and default sizes for multi_counter.
package multi_counter_pkg;
   localparam logic UP   = 1'b0;
   localparam logic DOWN = 1'b1;
   localparam logic WRAP = 1'b0;
   localparam logic SAT  = 1'b1;
   localparam int WIDTH_DEF = 64;
   localparam int NCH_DEF   = 4;
   localparam int PW_DEF    = 16;
endpackage

// File: rtl/multi_counter_channel.sv
// counter_channel: one up/down counter with clear/load, wrap or saturate, compare match and terminal-count pulse.
module counter_channel
   import multi_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic             down,
   input  logic             saturate,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] compare_value,
   output logic [WIDTH-1:0] count,
   output logic             match,
   output logic             tc
);
   logic             step, at_lim, moved, stepped_q;
   logic [WIDTH-1:0] nxt;
   always_comb begin
      step   = enable & tick & ~clear & ~load;
      at_lim = (down == DOWN) ? (count == '0) : (count == '1);
      moved  = step & ~((saturate == SAT) & at_lim);
      nxt    = clear ? '0 : load ? load_value : !moved ? count :
               (down == DOWN) ? count - WIDTH'(1) : count + WIDTH'(1);
   end
   // match looks at the count one cycle after the step that produced it
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         tc        <= 1'b0;
         stepped_q <= 1'b0;
         match     <= 1'b0;
      end else begin
         count     <= nxt;
         tc        <= step & at_lim;
         stepped_q <= moved;
         match     <= stepped_q & (count == compare_value);
      end
   end
endmodule

// File: rtl/multi_counter.sv
// multi_counter: NCH independent counters sharing a prescaler tick and an atomic snapshot register.
module multi_counter
   import multi_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NCH   = NCH_DEF,
   parameter int PW    = PW_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NCH-1:0]     enable,
   input  logic [NCH-1:0]     clear,
   input  logic [NCH-1:0]     load,
   input  logic [NCH*WIDTH-1:0] load_value,
   input  logic [NCH-1:0]     down,
   input  logic [NCH-1:0]     saturate,
   input  logic [PW-1:0]      prescale_div,
   input  logic [NCH*WIDTH-1:0] compare_value,
   input  logic               snap,
   output logic [NCH*WIDTH-1:0] count,
   output logic [NCH*WIDTH-1:0] snap_count,
   output logic               snap_valid,
   output logic [NCH-1:0]     match,
   output logic [NCH-1:0]     tc
);
   logic [PW-1:0] pre;
   logic          tick;
   // >= so a divisor lowered below the running count ticks and restarts immediately
   assign tick = pre >= prescale_div;
   always_ff @(posedge clk) begin
      if (reset) begin
         pre        <= '0;
         snap_count <= '0;
         snap_valid <= 1'b0;
      end else begin
         pre        <= tick ? '0 : pre + PW'(1);
         snap_valid <= snap;
         if (snap) snap_count <= count;
      end
   end
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      counter_channel #(.WIDTH(WIDTH)) u_ch (
         .clk          (clk),
         .reset        (reset),
         .tick         (tick),
         .enable       (enable[i]),
         .clear        (clear[i]),
         .load         (load[i]),
         .down         (down[i]),
         .saturate     (saturate[i]),
         .load_value   (load_value[i*WIDTH +: WIDTH]),
         .compare_value(compare_value[i*WIDTH +: WIDTH]),
         .count        (count[i*WIDTH +: WIDTH]),
         .match        (match[i]),
         .tc           (tc[i])
      );
   end
endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: directed scenario tasks for multi_counter with hand-computed expectations.
module tb_multi_counter;
   localparam int W = 64;
   localparam int N = 4;
   localparam logic [W-1:0] ONES = '1;
   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   enable = '0, clear = '0, load = '0, down = '0, saturate = '0;
   logic [N*W-1:0] load_value = '0, compare_value = '0;
   logic [15:0]    prescale_div = '0;
   logic           snap = 1'b0;
   logic [N*W-1:0] count, snap_count;
   logic           snap_valid;
   logic [N-1:0]   match, tc;
   int total = 0, bad = 0;

   multi_counter dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
      .load_value(load_value), .down(down), .saturate(saturate),
      .prescale_div(prescale_div), .compare_value(compare_value), .snap(snap),
      .count(count), .snap_count(snap_count), .snap_valid(snap_valid),
      .match(match), .tc(tc)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [W-1:0] cnt(input int i);
      return count[i*W +: W];
   endfunction

   task automatic test_reset();
      reset = 1'b1; enable = '1; load = '1; snap = 1'b1; load_value = '1;
      cyc(2);
      total++; if (count !== '0) begin bad++; $display("FAIL reset_count got %0h exp 0", count); end
      total++; if (snap_count !== '0) begin bad++; $display("FAIL reset_snap got %0h exp 0", snap_count); end
      total++; if ({snap_valid, match, tc} !== '0) begin bad++; $display("FAIL reset_pulses got %0h exp 0", {snap_valid, match, tc}); end
      enable = '0; load = '0; snap = 1'b0; load_value = '0; reset = 1'b0;
   endtask

   task automatic test_up();
      logic saw_tc = 1'b0;
      prescale_div = '0; enable = 4'b0001;
      for (int k = 0; k < 5; k++) begin cyc(1); saw_tc |= tc[0]; end
      enable = '0;
      total++; if (cnt(0) !== 64'd5) begin bad++; $display("FAIL up_count0 got %0d exp 5", cnt(0)); end
      total++; if (saw_tc !== 1'b0) begin bad++; $display("FAIL up_tc0 got %0b exp 0", saw_tc); end
   endtask

   task automatic test_wrap_sat();
      load = 4'b0010; load_value[W +: W] = ONES; cyc(1);
      load = '0; enable = 4'b0010; cyc(1);
      enable = '0;
      total++; if (cnt(1) !== '0) begin bad++; $display("FAIL wrap_count1 got %0h exp 0", cnt(1)); end
      total++; if (tc[1] !== 1'b1) begin bad++; $display("FAIL wrap_tc1 got %0b exp 1", tc[1]); end
      cyc(1);
      total++; if (tc[1] !== 1'b0) begin bad++; $display("FAIL wrap_tc1_single got %0b exp 0", tc[1]); end
      down = 4'b0010; enable = 4'b0010; cyc(1);
      enable = '0;
      total++; if (cnt(1) !== ONES) begin bad++; $display("FAIL wrapdn_count1 got %0h exp %0h", cnt(1), ONES); end
      total++; if (tc[1] !== 1'b1) begin bad++; $display("FAIL wrapdn_tc1 got %0b exp 1", tc[1]); end
      down = '0; saturate = 4'b0010; enable = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         total++; if (cnt(1) !== ONES) begin bad++; $display("FAIL sat_count1 step%0d got %0h exp %0h", k, cnt(1), ONES); end
         total++; if (tc[1] !== 1'b1) begin bad++; $display("FAIL sat_tc1 step%0d got %0b exp 1", k, tc[1]); end
      end
      enable = '0; cyc(1);
      total++; if (tc[1] !== 1'b0) begin bad++; $display("FAIL sat_tc1_idle got %0b exp 0", tc[1]); end
      saturate = '0;
   endtask

   task automatic test_prescale();
      reset = 1'b1; cyc(1);
      reset = 1'b0; prescale_div = 16'd3; enable = 4'b0100;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         total++; if (cnt(2) !== 64'((k + 1) / 4)) begin bad++; $display("FAIL presc_count2 cyc%0d got %0d exp %0d", k, cnt(2), (k + 1) / 4); end
      end
      enable = '0; prescale_div = '0;
   endtask

   task automatic test_match();
      compare_value[3*W +: W] = 64'd10; clear = 4'b1000; cyc(1);
      clear = '0; enable = 4'b1000;
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         total++; if (cnt(3) !== 64'(k)) begin bad++; $display("FAIL match_count3 k%0d got %0d exp %0d", k, cnt(3), k); end
         total++; if (match[3] !== (k == 11)) begin bad++; $display("FAIL match3 k%0d got %0b exp %0b", k, match[3], k == 11); end
      end
      enable = '0; load = 4'b1000; load_value[3*W +: W] = 64'd10; cyc(1);
      load = '0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         total++; if (match[3] !== 1'b0) begin bad++; $display("FAIL load_nomatch3 k%0d got %0b exp 0", k, match[3]); end
      end
   endtask

   task automatic test_snap();
      load = '1; load_value = {64'd10, 64'd9, 64'd8, 64'd7}; cyc(1);
      load = '0; snap = 1'b1; clear = 4'b0001; cyc(1);
      snap = 1'b0; clear = '0;
      total++; if (snap_count !== {64'd10, 64'd9, 64'd8, 64'd7}) begin bad++; $display("FAIL snap_count got %0h exp {10,9,8,7}", snap_count); end
      total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL snap_valid got %0b exp 1", snap_valid); end
      total++; if (cnt(0) !== '0) begin bad++; $display("FAIL snap_clear0 got %0d exp 0", cnt(0)); end
      cyc(1);
      total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL snap_valid_pulse got %0b exp 0", snap_valid); end
      snap = 1'b1; enable = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL snap_held_valid k%0d got %0b exp 1", k, snap_valid); end
         total++; if (snap_count[0 +: W] !== 64'(k)) begin bad++; $display("FAIL snap_held_cnt0 k%0d got %0d exp %0d", k, snap_count[0 +: W], k); end
      end
      snap = 1'b0; enable = '0;
   endtask

   task automatic test_reset_mid();
      prescale_div = 16'd2; enable = '1; cyc(3);
      reset = 1'b1; snap = 1'b1; load = '1; load_value = '1; cyc(1);
      total++; if (count !== '0) begin bad++; $display("FAIL mid_count got %0h exp 0", count); end
      total++; if (snap_count !== '0) begin bad++; $display("FAIL mid_snap got %0h exp 0", snap_count); end
      total++; if ({snap_valid, match, tc} !== '0) begin bad++; $display("FAIL mid_pulses got %0h exp 0", {snap_valid, match, tc}); end
      reset = 1'b0; snap = 1'b0; load = '0; enable = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         total++; if (cnt(0) !== 64'((k + 1) / 3)) begin bad++; $display("FAIL resume_count0 cyc%0d got %0d exp %0d", k, cnt(0), (k + 1) / 3); end
      end
      enable = '0;
   endtask

   initial begin
      #1;
      test_reset();
      test_up();
      test_wrap_sat();
      test_prescale();
      test_match();
      test_snap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
